// File: rtl/audio_pkg.sv
// Shared audio definitions: sample width, default source count, scheduler
// states and saturation limits.
package audio_pkg;

    localparam int SW       = 16;
    localparam int NSRC_DEF = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GATHER  = 2'd1,
        CLAMP   = 2'd2,
        PUBLISH = 2'd3
    } state_t;

    localparam logic [SW-1:0] SAT_MAX = 16'h7FFF;
    localparam logic [SW-1:0] SAT_MIN = 16'h8000;

endpackage

// File: rtl/audio_edge_sync.sv
// Two-flop synchronizer for an I2S-clock-derived signal with a one-cycle
// rising-edge strobe in the clk_i domain.
module audio_edge_sync (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic async_i,
    output logic rise_o
);

    // sh[1:0] is the synchronizer, sh[2] the previous synchronized value.
    logic [2:0] sh;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sh <= '0;
        end else begin
            sh <= {sh[1:0], async_i};
        end
    end

    assign rise_o = sh[1] & ~sh[2];

endmodule

// File: rtl/audio_mix_sched.sv
// Per-frame source poller and mixer feeding the I2S transmitter.
// Define AUDIO_MIX_SATURATE_EN to saturate the mix instead of wrapping it.
module audio_mix_sched
    import audio_pkg::*;
#(
    parameter int NSRC = NSRC_DEF
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              lrclk_i,
    input  logic [NSRC-1:0]   src_valid_i,
    output logic [NSRC-1:0]   src_ready_o,
    input  logic [NSRC*SW-1:0] src_left_i,
    input  logic [NSRC*SW-1:0] src_right_i,
    input  logic [NSRC-1:0]   en_i,
    input  logic [NSRC*4-1:0] gain_i,
    input  logic              mute_i,
    input  logic              clr_i,
    output logic [SW-1:0]     left_o,
    output logic [SW-1:0]     right_o,
    output logic              sample_stb_o,
    output logic [NSRC-1:0]   underrun_o,
    output logic              overrun_o,
    output logic [1:0]        state_o
);

    localparam int AW = SW + $clog2(NSRC);
    localparam int IW = $clog2(NSRC);

    // Handshake: a source holds valid and data until it sees ready; ready is
    // a single-cycle strobe during the GATHER slot of that source, and the
    // sample is consumed at the end of that cycle.

    state_t               state;
    logic [IW-1:0]        idx;
    logic [NSRC-1:0]      en_q;
    logic [NSRC*4-1:0]    gain_q;
    logic                 mute_q;
    logic signed [AW-1:0] acc_l, acc_r;
    logic [SW-1:0]        pub_l, pub_r;

    logic                 frame_start;
    logic [SW-1:0]        cur_l, cur_r;
    logic [3:0]           cur_g;
    logic signed [SW-1:0] sh_l, sh_r;
    logic [AW-1:0]        ext_l, ext_r;
    logic [NSRC-1:0]      sel_oh;
    logic                 take;
    logic [NSRC-1:0]      under_set;
    logic                 over_set;
    logic [SW-1:0]        red_l, red_r;

    audio_edge_sync u_lrclk_sync (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .async_i (lrclk_i),
        .rise_o  (frame_start)
    );

    always_comb begin
        cur_l     = src_left_i[idx*SW +: SW];
        cur_r     = src_right_i[idx*SW +: SW];
        cur_g     = gain_q[idx*4 +: 4];
        sh_l      = $signed(cur_l) >>> cur_g;
        sh_r      = $signed(cur_r) >>> cur_g;
        ext_l     = {{(AW-SW){sh_l[SW-1]}}, sh_l};
        ext_r     = {{(AW-SW){sh_r[SW-1]}}, sh_r};
        sel_oh    = NSRC'(1) << idx;
        take      = (state == GATHER) && en_q[idx] && src_valid_i[idx];
        under_set = ((state == GATHER) && en_q[idx] && !src_valid_i[idx]) ? sel_oh : '0;
        over_set  = frame_start && (state != IDLE);
    end

    assign src_ready_o = take ? sel_oh : '0;
    assign state_o     = state;

    // Accumulators carry log2(NSRC) guard bits, so only this reduction can lose range.
    always_comb begin
        red_l = acc_l[SW-1:0];
        red_r = acc_r[SW-1:0];
`ifdef AUDIO_MIX_SATURATE_EN
        if (acc_l[AW-1:SW-1] != {(AW-SW+1){acc_l[AW-1]}}) begin
            red_l = acc_l[AW-1] ? SAT_MIN : SAT_MAX;
        end
        if (acc_r[AW-1:SW-1] != {(AW-SW+1){acc_r[AW-1]}}) begin
            red_r = acc_r[AW-1] ? SAT_MIN : SAT_MAX;
        end
`endif
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state        <= IDLE;
            idx          <= '0;
            en_q         <= '0;
            gain_q       <= '0;
            mute_q       <= 1'b0;
            acc_l        <= '0;
            acc_r        <= '0;
            pub_l        <= '0;
            pub_r        <= '0;
            left_o       <= '0;
            right_o      <= '0;
            sample_stb_o <= 1'b0;
            underrun_o   <= '0;
            overrun_o    <= 1'b0;
        end else begin
            sample_stb_o <= 1'b0;
            // Set has priority over a coincident clear.
            underrun_o   <= (underrun_o & ~{NSRC{clr_i}}) | under_set;
            overrun_o    <= (overrun_o & ~clr_i) | over_set;
            case (state)
                IDLE: begin
                    if (frame_start) begin
                        en_q   <= en_i;
                        gain_q <= gain_i;
                        mute_q <= mute_i;
                        acc_l  <= '0;
                        acc_r  <= '0;
                        idx    <= '0;
                        state  <= GATHER;
                    end
                end
                GATHER: begin
                    if (take) begin
                        acc_l <= acc_l + ext_l;
                        acc_r <= acc_r + ext_r;
                    end
                    if (idx == IW'(NSRC-1)) begin
                        state <= CLAMP;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                CLAMP: begin
                    pub_l <= mute_q ? '0 : red_l;
                    pub_r <= mute_q ? '0 : red_r;
                    state <= PUBLISH;
                end
                PUBLISH: begin
                    left_o       <= pub_l;
                    right_o      <= pub_r;
                    sample_stb_o <= 1'b1;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_audio_mix_sched.sv
// Directed bench for audio_mix_sched: frame-level mixing model with an
// expected queue of published pairs, checked every cycle.
module tb_audio_mix_sched;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b1;
    logic        lrclk_i = 1'b0;
    logic [3:0]  src_valid_i;
    logic [3:0]  src_ready_o;
    logic [63:0] src_left_i;
    logic [63:0] src_right_i;
    logic [3:0]  en_i;
    logic [15:0] gain_i;
    logic        mute_i;
    logic        clr_i;
    logic [15:0] left_o;
    logic [15:0] right_o;
    logic        sample_stb_o;
    logic [3:0]  underrun_o;
    logic        overrun_o;
    logic [1:0]  state_o;

    audio_mix_sched #(.NSRC(4)) dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .lrclk_i      (lrclk_i),
        .src_valid_i  (src_valid_i),
        .src_ready_o  (src_ready_o),
        .src_left_i   (src_left_i),
        .src_right_i  (src_right_i),
        .en_i         (en_i),
        .gain_i       (gain_i),
        .mute_i       (mute_i),
        .clr_i        (clr_i),
        .left_o       (left_o),
        .right_o      (right_o),
        .sample_stb_o (sample_stb_o),
        .underrun_o   (underrun_o),
        .overrun_o    (overrun_o),
        .state_o      (state_o)
    );

    // clock/reset
    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // model state and scoreboard
    logic [31:0] exp_q[$];
    logic [31:0] cur_pub = '0;
    logic [3:0]  exp_under = '0;
    logic        exp_over = 1'b0;
    logic [15:0] lv[4];
    logic [15:0] rv[4];
    logic [3:0]  gv[4];
    logic [3:0]  offer = '0;
    int          rdy_cnt[4];
    int          base[4];
    logic        saw_stb;
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] mix(input int s);
        logic [31:0] v;
        v = s;
`ifdef AUDIO_MIX_SATURATE_EN
        if (s > 32767) v = 32'h0000_7FFF;
        if (s < -32768) v = 32'hFFFF_8000;
`endif
        return v[15:0];
    endfunction

    // Frame-level model: sum of enabled, offered sources after attenuation.
    task automatic predict();
        int sl, sr;
        sl = 0;
        sr = 0;
        for (int i = 0; i < 4; i++) begin
            if (en_i[i] && offer[i]) begin
                sl += int'($signed(lv[i])) >>> gv[i];
                sr += int'($signed(rv[i])) >>> gv[i];
            end
        end
        exp_q.push_back(mute_i ? 32'h0 : {mix(sl), mix(sr)});
        exp_under = exp_under | (en_i & ~offer);
    endtask

    // driver tasks
    task automatic setup(input logic [3:0] en, input logic [3:0] off, input logic m);
        en_i   = en;
        offer  = off;
        mute_i = m;
        for (int i = 0; i < 4; i++) begin
            src_left_i[i*16 +: 16]  = lv[i];
            src_right_i[i*16 +: 16] = rv[i];
            gain_i[i*4 +: 4]        = gv[i];
            base[i]                 = rdy_cnt[i];
        end
        src_valid_i = off;
    endtask

    // One clock cycle: per-cycle compare at the negedge, then source response.
    task automatic tick();
        logic [3:0]  rdy;
        logic [31:0] e;
        @(negedge clk_i);
        rdy = src_ready_o;
        chk("ready_onehot", {31'b0, $countones(rdy) <= 1}, 32'd1);
        chk("ready_to_valid", {28'b0, rdy & ~src_valid_i}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            if (rdy[i]) rdy_cnt[i]++;
        end
        if (!rst_n_i) begin
            chk("reset_outputs", {left_o, right_o}, 32'd0);
            chk("reset_flags", {23'b0, sample_stb_o, src_ready_o, underrun_o, overrun_o}, 32'd0);
            chk("reset_state", {30'b0, state_o}, 32'd0);
        end
        if (sample_stb_o) begin
            saw_stb = 1'b1;
            if (exp_q.size() == 0) begin
                chk("spurious_stb", {31'b0, sample_stb_o}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("left", {16'b0, left_o}, {16'b0, e[31:16]});
                chk("right", {16'b0, right_o}, {16'b0, e[15:0]});
                cur_pub = e;
            end
        end else begin
            chk("hold_pair", {left_o, right_o}, cur_pub);
        end
        @(posedge clk_i);
        #1;
        src_valid_i = src_valid_i & ~rdy;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic wait_stb();
        saw_stb = 1'b0;
        for (int k = 0; k < 25 && !saw_stb; k++) tick();
        chk("stb_seen", {31'b0, saw_stb}, 32'd1);
    endtask

    task automatic wait_gather();
        logic ok;
        ok = 1'b0;
        for (int k = 0; k < 12 && !ok; k++) begin
            tick();
            ok = (state_o == 2'd1);
        end
        chk("gather_reached", {31'b0, ok}, 32'd1);
    endtask

    task automatic check_flags();
        chk("underrun", {28'b0, underrun_o}, {28'b0, exp_under});
        chk("overrun", {31'b0, overrun_o}, {31'b0, exp_over});
    endtask

    task automatic run_frame();
        predict();
        lrclk_i = 1'b1;
        wait_stb();
        lrclk_i = 1'b0;
        ticks(4);
        check_flags();
    endtask

    task automatic check_ready(input int c0, input int c1, input int c2, input int c3);
        chk("ready_cnt0", rdy_cnt[0] - base[0], c0);
        chk("ready_cnt1", rdy_cnt[1] - base[1], c1);
        chk("ready_cnt2", rdy_cnt[2] - base[2], c2);
        chk("ready_cnt3", rdy_cnt[3] - base[3], c3);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            lv[i] = '0; rv[i] = '0; gv[i] = '0; rdy_cnt[i] = 0; base[i] = 0;
        end
        clr_i = 1'b0;
        setup(4'b0000, 4'b0000, 1'b0);

        // Reset with lrclk toggling
        #2 rst_n_i = 1'b0;
        for (int k = 0; k < 6; k++) begin
            lrclk_i = ~lrclk_i;
            tick();
        end
        lrclk_i = 1'b0;
        ticks(2);
        rst_n_i = 1'b1;
        ticks(3);

        // Two valid sources, two disabled
        lv[0] = 16'h1000; rv[0] = 16'hF000; gv[0] = 4'd0;
        lv[1] = 16'h0200; rv[1] = 16'h0400; gv[1] = 4'd1;
        lv[2] = 16'h2222; rv[2] = 16'h3333; gv[2] = 4'd0;
        lv[3] = 16'h4444; rv[3] = 16'h5555; gv[3] = 4'd0;
        setup(4'b0011, 4'b1111, 1'b0);
        run_frame();
        chk("lit_left_mix", {16'b0, left_o}, 32'h1100);
        chk("lit_right_mix", {16'b0, right_o}, 32'hF200);
        check_ready(1, 1, 0, 0);

        // Four full-scale sources: saturate or wrap
        for (int i = 0; i < 4; i++) begin
            lv[i] = 16'h7000; rv[i] = 16'h9000; gv[i] = 4'd0;
        end
        setup(4'b1111, 4'b1111, 1'b0);
        run_frame();
`ifdef AUDIO_MIX_SATURATE_EN
        chk("lit_left_sat", {16'b0, left_o}, 32'h7FFF);
        chk("lit_right_sat", {16'b0, right_o}, 32'h8000);
`else
        chk("lit_left_wrap", {16'b0, left_o}, 32'hC000);
        chk("lit_right_wrap", {16'b0, right_o}, 32'h4000);
`endif
        check_ready(1, 1, 1, 1);

        // Deep attenuation of negative and edge samples
        lv[0] = 16'h8000; rv[0] = 16'h8001; gv[0] = 4'd15;
        lv[1] = 16'h0004; rv[1] = 16'h7FFF; gv[1] = 4'd15;
        setup(4'b0011, 4'b0011, 1'b0);
        gain_i[3:0] = 4'd15; gain_i[7:4] = 4'd2; gv[0] = 4'd15; gv[1] = 4'd2;
        rv[0] = 16'h8001; gain_i[3:0] = 4'd4; gv[0] = 4'd4;
        lv[0] = 16'h8000;
        // src0: L 0x8000>>>4 = 0xF800, R 0x8001>>>4 = 0xF800; src1: L 4>>>2 = 1, R 0x7FFF>>>2 = 0x1FFF
        run_frame();
        chk("lit_left_shift", {16'b0, left_o}, 32'hF801);
        chk("lit_right_shift", {16'b0, right_o}, 32'h17FF);

        // Underrun on source 2, with a coincident clear
        lv[0] = 16'h0100; rv[0] = 16'h0001; gv[0] = 4'd0;
        lv[1] = 16'h0010; rv[1] = 16'h0002; gv[1] = 4'd0;
        lv[2] = 16'h4000; rv[2] = 16'h4000; gv[2] = 4'd0;
        setup(4'b0111, 4'b0011, 1'b0);
        predict();
        lrclk_i = 1'b1;
        wait_gather();
        ticks(2);
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
        wait_stb();
        lrclk_i = 1'b0;
        ticks(4);
        check_flags();
        chk("lit_underrun", {28'b0, underrun_o}, 32'h4);
        chk("lit_left_under", {16'b0, left_o}, 32'h0110);
        check_ready(1, 1, 0, 0);

        // Clear the sticky flags
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
        exp_under = '0;
        tick();
        check_flags();

        // Second lrclk edge during GATHER
        for (int i = 0; i < 4; i++) begin
            lv[i] = 16'(16'h0100 * (i + 1)); rv[i] = 16'(16'h0010 * (i + 1)); gv[i] = 4'd0;
        end
        setup(4'b1111, 4'b1111, 1'b0);
        predict();
        lrclk_i = 1'b1;
        wait_gather();
        lrclk_i = 1'b0;
        tick();
        lrclk_i = 1'b1;
        wait_stb();
        ticks(12);
        exp_over = 1'b1;
        check_flags();
        chk("lit_left_over", {16'b0, left_o}, 32'h0A00);
        check_ready(1, 1, 1, 1);
        lrclk_i = 1'b0;
        ticks(3);
        setup(4'b1111, 4'b1111, 1'b0);
        run_frame();
        check_ready(1, 1, 1, 1);

        // Mute still consumes sources
        setup(4'b1111, 4'b1111, 1'b1);
        run_frame();
        chk("lit_mute", {left_o, right_o}, 32'h0);
        check_ready(1, 1, 1, 1);
        mute_i = 1'b0;

        // Reset in the middle of GATHER
        setup(4'b1111, 4'b1111, 1'b0);
        predict();
        lrclk_i = 1'b1;
        wait_gather();
        tick();
        rst_n_i = 1'b0;
        exp_q.delete();
        cur_pub = '0;
        exp_under = '0;
        exp_over = 1'b0;
        ticks(2);
        lrclk_i = 1'b0;
        tick();
        rst_n_i = 1'b1;
        ticks(3);
        chk("post_reset_state", {30'b0, state_o}, 32'd0);
        check_flags();
        setup(4'b0011, 4'b0011, 1'b0);
        run_frame();
        chk("lit_after_reset", {16'b0, left_o}, 32'h0300);
        check_ready(1, 1, 0, 0);

        chk("queue_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
